product_accumulator: RTL and testbench

- Downstream consumer of the 2-bit multiplier's 4-bit product.
- Accepts a burst of COUNT products over a valid/ready handshake and sums them into a saturating accumulator.
- Presents the final sum with an output valid/ready handshake.
- Sits between the multiplier datapath and the board display/readout logic of the lab design.

---
 rtl/mul_pkg.sv | 42 ++++
 rtl/product_accumulator.sv | 101 ++++++++++
 tb/tb_product_accumulator.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and helpers for the multiplier/accumulator lab datapath.
// Holds the accumulator FSM encoding, default widths and the saturating adder.
package mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int PROD_W    = 4;
   localparam int ACC_W     = 10;
   localparam int BURST_LEN = 8;

   // Widest accumulator the helper supports; callers truncate to their own width.
   localparam int SAT_W = 32;

   typedef struct packed {
      logic [SAT_W-1:0] sum;
      logic             ovf;
   } sat_t;

   // One extra carry bit lets any sum above 2^aw-1 be detected and clamped.
   function automatic sat_t sat_add(input logic [SAT_W-1:0] acc,
                                    input logic [SAT_W-1:0] val,
                                    input int               aw);
      sat_t         res;
      logic [SAT_W:0] s;
      logic [SAT_W:0] max;
      s   = {1'b0, acc} + {1'b0, val};
      max = ((SAT_W+1)'(1) << aw) - (SAT_W+1)'(1);
      if (s > max) begin
         res.sum = max[SAT_W-1:0];
         res.ovf = 1'b1;
      end else begin
         res.sum = s[SAT_W-1:0];
         res.ovf = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/product_accumulator.sv
// Sums a burst of COUNT products into a saturating accumulator; result valid the cycle after the last accept.
// in_ready is a registered state decode; the result holds in HOLD until out_ready, with no limit on stall.
module product_accumulator
   import mul_pkg::*;
#(
   parameter int PW    = PROD_W,
   parameter int AW    = ACC_W,
   parameter int COUNT = BURST_LEN
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [PW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [AW-1:0] out_sum,
   output logic          out_ovf,
   output logic          busy
);

   localparam int CW = $clog2(COUNT + 1);

   if (AW < PW || COUNT < 1 || AW >= SAT_W) begin : g_bad_param
      $error("product_accumulator: illegal PW/AW/COUNT combination");
   end

   state_t         state;
   state_t         state_nxt;
   logic [AW-1:0]  acc;
   logic [CW-1:0]  cnt;
   logic           ovf;

   logic           accept;
   logic           last;
   sat_t           sat_res;
   logic [SAT_W-AW-1:0] sat_hi_unused;

   assign accept = in_valid & in_ready;
   assign last   = (cnt == CW'(COUNT - 1));

   assign sat_res       = sat_add(SAT_W'(acc), SAT_W'(in_data), AW);
   assign sat_hi_unused = sat_res.sum[SAT_W-1:AW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)              state_nxt = ACC;
         ACC:     if (accept && last)     state_nxt = HOLD;
         HOLD:    if (out_ready)          state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         ACC: begin
            in_ready = 1'b1;
            busy     = 1'b1;
         end
         HOLD: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath only moves on start-from-IDLE or an accept, so the result survives back into IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (state == IDLE && start) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else if (accept) begin
         acc <= sat_res.sum[AW-1:0];
         cnt <= cnt + CW'(1);
         ovf <= ovf | sat_res.ovf;
      end
   end

   assign out_sum = acc;
   assign out_ovf = ovf;

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench: drivers push expected results, a monitor pops on each output handshake.
// Instance a uses default widths, instance b uses AW=6 to reach saturation.
module tb_product_accumulator;

   logic       clk;
   logic       rst_n;
   logic       st   [2];
   logic       iv   [2];
   logic [3:0] idat [2];
   logic       ord  [2];
   logic       ir   [2];
   logic       ov   [2];
   logic       ovf  [2];
   logic       bsy  [2];
   logic [9:0] a_sum;
   logic [5:0] b_sum;

   typedef struct {
      logic [9:0] sum;
      logic       ovf;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] prod [8];
   int         gaps [8];

   product_accumulator dut_a (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(iv[0]), .in_ready(ir[0]),
      .in_data(idat[0]), .out_valid(ov[0]), .out_ready(ord[0]), .out_sum(a_sum),
      .out_ovf(ovf[0]), .busy(bsy[0])
   );

   product_accumulator #(.PW(4), .AW(6), .COUNT(8)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(iv[1]), .in_ready(ir[1]),
      .in_data(idat[1]), .out_valid(ov[1]), .out_ready(ord[1]), .out_sum(b_sum),
      .out_ovf(ovf[1]), .busy(bsy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] get_sum(input int s);
      return (s == 0) ? a_sum : {4'b0000, b_sum};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every completed output handshake against the scoreboard.
   always @(negedge clk) begin
      for (int s = 0; s < 2; s++) begin
         if (rst_n && ov[s] && ord[s]) begin
            exp_t e;
            if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = (s == 0) ? q0.pop_front() : q1.pop_front();
               chk("mon_sum", 32'(get_sum(s)), 32'(e.sum));
               chk("mon_ovf", 32'(ovf[s]), 32'(e.ovf));
            end
         end
      end
   end

   task automatic run_burst(input int s, input int start_at, input logic [9:0] es,
                            input logic eo, input int hold, input bit start_on_release);
      exp_t e;
      st[s] = 1'b1;
      tick();
      st[s] = 1'b0;
      chk("busy_after_start", 32'(bsy[s]), 32'd1);
      chk("sum_cleared", 32'(get_sum(s)), 32'd0);
      for (int i = 0; i < 8; i++) begin
         for (int g = 0; g < gaps[i]; g++) begin
            iv[s]   = 1'b0;
            idat[s] = 4'hF;
            tick();
            chk("gap_no_out", 32'(ov[s]), 32'd0);
            chk("gap_ready", 32'(ir[s]), 32'd1);
         end
         iv[s]   = 1'b1;
         idat[s] = prod[i];
         if (i == start_at) st[s] = 1'b1;
         tick();
         st[s] = 1'b0;
         iv[s] = 1'b0;
         if (i < 7) chk("ready_in_acc", 32'(ir[s]), 32'd1);
      end
      e.sum = es;
      e.ovf = eo;
      if (s == 0) q0.push_back(e); else q1.push_back(e);
      chk("latency_out_valid", 32'(ov[s]), 32'd1);
      chk("hold_not_ready", 32'(ir[s]), 32'd0);
      for (int h = 0; h < hold; h++) begin
         if (h % 5 == 2) st[s] = 1'b1;
         tick();
         st[s] = 1'b0;
         chk("hold_valid", 32'(ov[s]), 32'd1);
         chk("hold_sum", 32'(get_sum(s)), 32'(es));
         chk("hold_ovf", 32'(ovf[s]), 32'(eo));
         chk("hold_ready", 32'(ir[s]), 32'd0);
      end
      ord[s] = 1'b1;
      if (start_on_release) st[s] = 1'b1;
      tick();
      ord[s] = 1'b0;
      st[s]  = 1'b0;
      chk("out_valid_drop", 32'(ov[s]), 32'd0);
      chk("idle_busy", 32'(bsy[s]), 32'd0);
      tick();
      chk("idle_stays", 32'(bsy[s]), 32'd0);
      chk("sum_kept", 32'(get_sum(s)), 32'(es));
      chk("ovf_kept", 32'(ovf[s]), 32'(eo));
   endtask

   task automatic set_burst(input int p0, input int p1, input int p2, input int p3,
                            input int p4, input int p5, input int p6, input int p7,
                            input int gap_odd);
      prod[0] = 4'(p0); prod[1] = 4'(p1); prod[2] = 4'(p2); prod[3] = 4'(p3);
      prod[4] = 4'(p4); prod[5] = 4'(p5); prod[6] = 4'(p6); prod[7] = 4'(p7);
      for (int i = 0; i < 8; i++) gaps[i] = (i % 2 == 1) ? gap_odd : 0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      for (int s = 0; s < 2; s++) begin
         st[s] = 1'b0; iv[s] = 1'b0; idat[s] = 4'h0; ord[s] = 1'b0;
      end
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset state, then in_valid must be ignored in IDLE.
      for (int s = 0; s < 2; s++) begin
         chk("rst_in_ready", 32'(ir[s]), 32'd0);
         chk("rst_out_valid", 32'(ov[s]), 32'd0);
         chk("rst_sum", 32'(get_sum(s)), 32'd0);
         chk("rst_ovf", 32'(ovf[s]), 32'd0);
         chk("rst_busy", 32'(bsy[s]), 32'd0);
      end
      iv[0] = 1'b1; idat[0] = 4'd9;
      tick();
      tick();
      iv[0] = 1'b0;
      chk("idle_ignores_valid_sum", 32'(a_sum), 32'd0);
      chk("idle_ignores_valid_busy", 32'(bsy[0]), 32'd0);

      // Basic burst 8x9.
      set_burst(9, 9, 9, 9, 9, 9, 9, 9, 0);
      run_burst(0, -1, 10'd72, 1'b0, 0, 1'b0);

      // Gapped input.
      set_burst(0, 1, 2, 3, 4, 6, 9, 2, 2);
      run_burst(0, -1, 10'd27, 1'b0, 0, 1'b0);

      // Saturation on the narrow accumulator, then ovf cleared by next start.
      set_burst(9, 9, 9, 9, 9, 9, 9, 9, 0);
      run_burst(1, -1, 10'd63, 1'b1, 0, 1'b0);
      set_burst(1, 1, 1, 1, 1, 1, 1, 1, 1);
      run_burst(1, -1, 10'd8, 1'b0, 0, 1'b0);

      // Backpressure for 20 cycles with ignored starts, start coincident with release.
      set_burst(1, 2, 3, 4, 5, 6, 7, 8, 0);
      run_burst(0, -1, 10'd36, 1'b0, 20, 1'b1);

      // Reset mid-burst after 4 accepts.
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         iv[0] = 1'b1; idat[0] = 4'd5;
         tick();
      end
      iv[0] = 1'b0;
      chk("partial_sum", 32'(a_sum), 32'd20);
      rst_n = 1'b0;
      #1;
      chk("midrst_sum", 32'(a_sum), 32'd0);
      chk("midrst_busy", 32'(bsy[0]), 32'd0);
      chk("midrst_in_ready", 32'(ir[0]), 32'd0);
      chk("midrst_out_valid", 32'(ov[0]), 32'd0);
      chk("midrst_ovf", 32'(ovf[0]), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      set_burst(2, 2, 2, 2, 2, 2, 2, 2, 0);
      run_burst(0, -1, 10'd16, 1'b0, 0, 1'b0);

      // Start pulsed together with the 4th product must not restart.
      set_burst(3, 5, 7, 11, 13, 15, 1, 2, 1);
      run_burst(0, 3, 10'd57, 1'b0, 3, 1'b0);

      tick();
      tick();
      chk("scoreboard_a_empty", 32'(q0.size()), 32'd0);
      chk("scoreboard_b_empty", 32'(q1.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
